basilisk_sqrt_operation: RTL and testbench
==========================================

# basilisk_sqrt_operation

Iterative mantissa stage of the Basilisk FSQRT.S pipeline. It sits directly downstream of the sqrt exponent stage and consumes its `basilisk_sqrt_operation_t` stream. It runs a radix-2 restoring digit recurrence on the pre-aligned radicand and hands a 26-bit root plus sticky to the normalize/round stage. It is blocking: one operation is in flight at a time.

## Interface
- `ITERATIONS_PER_CYCLE`, default 1: recurrence steps per clock. Legal values are 1 and 2; any other value is an elaboration error.
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Asserts when 0 and releases synchronously to `clk`.
- `sqrt_exponent_command.valid`, input, 1: the upstream operation is valid.
- `sqrt_exponent_command.ready`, output, 1: the block accepts the operation.
- `sqrt_exponent_command.payload`, input, `$bits(basilisk_sqrt_operation_t)`. Fields:
  - `result`: sign, exponent, special flags nan/inf/zero/invalid, and a 26-bit radicand R in 2.24 fixed point, R ∈ [1,4).
  - `mode`
  - `dest_reg_addr`
- `sqrt_result_command.valid`, output, 1: the result is valid.
- `sqrt_result_command.ready`, input, 1: downstream accepts the result.
- `sqrt_result_command.payload`, output, `$bits(basilisk_sqrt_result_t)`. Fields:
  - upstream `result` with the radicand replaced by root Q (26 bits, 1.25 fixed point)
  - `sticky`
  - `mode`
  - `dest_reg_addr`

## Operation
- States:
  - IDLE: input ready, output invalid.
  - ITERATE: recurrence runs; the cycle counter decrements.
  - DONE: output valid and held.
- Transitions:
  - IDLE → ITERATE on input handshake.
  - ITERATE → DONE when the counter reaches 0.
  - DONE → IDLE on output handshake with no new input.
  - DONE → ITERATE when output and input handshake in the same cycle. This back-to-back case is legal.
- `sqrt_exponent_command.ready` = (state==IDLE) | (state==DONE & `sqrt_result_command.ready`). It is 0 while `rst` is asserted.
- Load on accept:
  - remainder rem (28 bits) = 0
  - Q = 0
  - shift register S (52 bits) = {R, 26'b0}
  - counter = 26/ITERATIONS_PER_CYCLE − 1
  - pass-through fields latched
- One recurrence step:
  - rem' = {rem[25:0], S[51:50]}
  - S <<= 2
  - t = rem' − {Q, 2'b01}, computed 28 bits wide
  - if t ≥ 0: rem = t, Q = {Q[24:0],1}
  - else: rem = rem', Q = {Q[24:0],0}
- 26 steps in total. Final `sticky` = (rem != 0).
- Output payload registers are written only on entry to DONE and held stable while valid & !ready.
- Special operands (nan/inf/zero/invalid flag set): see Configuration.

## Timing
- Latency: input accepted at edge k → `sqrt_result_command.valid` high after edge k + 26/ITERATIONS_PER_CYCLE + 1.
  - 27 cycles at ITERATIONS_PER_CYCLE=1.
  - 14 cycles at ITERATIONS_PER_CYCLE=2.
- Throughput: one operation per latency period when downstream is always ready, because DONE accepts the next input.
- Output backpressure stalls indefinitely in DONE. No data is lost and the payload stays constant.
- Reset values:
  - state = IDLE
  - `sqrt_result_command.valid` = 0
  - output payload = 0
  - counter = 0
  - `sqrt_exponent_command.ready` = 0 during reset, 1 on the first cycle after release
- Reset mid-ITERATE or mid-DONE aborts the operation. No output is produced for it.

## Configuration
- `BASILISK_SQRT_BYPASS_EN` defined:
  - An operand with any special flag goes IDLE → DONE in one cycle, so valid is asserted after edge k+1.
  - Q = 0 and sticky = 0.
  - The flags pass through unchanged.
- Undefined: special operands run the full 26-step recurrence with the normal latency. Q and sticky are whatever the recurrence yields. The flags still pass through, and downstream ignores Q.

## Structure
- Package `basilisk`:
  - `basilisk_sqrt_result_t`
  - `BASILISK_SQRT_ROOT_WIDTH = 26`
  - `BASILISK_SQRT_REM_WIDTH = 28`
- Package `fpu_sqrt`: an optional `fpu_sqrt_step` function that mirrors the sub-module for reuse by the reference model.
- Sub-module `basilisk_sqrt_step`: one combinational recurrence step with inputs (rem, Q, S) and outputs (rem, Q, S). It is instantiated ITERATIONS_PER_CYCLE times in a chain.
- Flow control uses a hand-written FSM, not `std_flow_lite`, because the block is multi-cycle.

## Test plan
- R=26'h1000000 (1.0), downstream always ready, ITERATIONS_PER_CYCLE=1 → Q=26'h2000000, sticky=0, valid exactly 27 cycles after accept.
- R=26'h2000000 (2.0) → Q=26'h2D413CC, sticky=1. R=26'h2400000 (2.25) → Q=26'h3000000, sticky=0.
- Two back-to-back operations with downstream ready held low 5 cycles during the first DONE:
  - the first payload stays stable throughout the stall
  - the second input is accepted on the same edge as the first output handshake
  - dest_reg_addr ordering is preserved
- Zero-flagged operand:
  - with `BASILISK_SQRT_BYPASS_EN`: valid after 1 cycle, Q=0, sticky=0, flags unchanged
  - without it: valid after 27 cycles, flags unchanged
- `rst` pulled low at ITERATE cycle 10, then released:
  - valid stays 0 and no output appears for the aborted operation
  - ready = 1 on the cycle after release
  - the next operation R=26'h1000000 gives the correct result
- ITERATIONS_PER_CYCLE=2 with 1000 random R ∈ [1,4): the Q and sticky bits match the reference model and the latency is 14.

Source files
------------

// File: rtl/basilisk_pkg.sv
// rtl/basilisk_pkg.sv - Shared types and constants for the Basilisk FSQRT.S mantissa stage
package basilisk;

    localparam int BASILISK_SQRT_ROOT_WIDTH = 26;
    localparam int BASILISK_SQRT_REM_WIDTH  = 28;
    localparam int BASILISK_SQRT_EXP_WIDTH  = 10;
    localparam int BASILISK_SQRT_MODE_WIDTH = 3;
    localparam int BASILISK_SQRT_ADDR_WIDTH = 5;

    localparam logic [1:0] SQRT_IDLE    = 2'd0;
    localparam logic [1:0] SQRT_ITERATE = 2'd1;
    localparam logic [1:0] SQRT_DONE    = 2'd2;

    // mant holds the 2.24 radicand upstream and the 1.25 root downstream
    typedef struct packed {
        logic                                sign;
        logic [BASILISK_SQRT_EXP_WIDTH-1:0]  exponent;
        logic                                nan;
        logic                                inf;
        logic                                zero;
        logic                                invalid;
        logic [BASILISK_SQRT_ROOT_WIDTH-1:0] mant;
    } basilisk_sqrt_value_t;

    typedef struct packed {
        basilisk_sqrt_value_t                result;
        logic [BASILISK_SQRT_MODE_WIDTH-1:0] mode;
        logic [BASILISK_SQRT_ADDR_WIDTH-1:0] dest_reg_addr;
    } basilisk_sqrt_operation_t;

    typedef struct packed {
        basilisk_sqrt_value_t                result;
        logic                                sticky;
        logic [BASILISK_SQRT_MODE_WIDTH-1:0] mode;
        logic [BASILISK_SQRT_ADDR_WIDTH-1:0] dest_reg_addr;
    } basilisk_sqrt_result_t;

    function automatic logic basilisk_sqrt_is_special(input basilisk_sqrt_value_t v);
        return v.nan | v.inf | v.zero | v.invalid;
    endfunction

endpackage

// File: rtl/basilisk_sqrt_step.sv
// rtl/basilisk_sqrt_step.sv - One combinational radix-2 restoring square-root step
module basilisk_sqrt_step
    import basilisk::*;
(
    input  logic [BASILISK_SQRT_REM_WIDTH-1:0]    rem_i,
    input  logic [BASILISK_SQRT_ROOT_WIDTH-1:0]   q_i,
    input  logic [2*BASILISK_SQRT_ROOT_WIDTH-1:0] s_i,
    output logic [BASILISK_SQRT_REM_WIDTH-1:0]    rem_o,
    output logic [BASILISK_SQRT_ROOT_WIDTH-1:0]   q_o,
    output logic [2*BASILISK_SQRT_ROOT_WIDTH-1:0] s_o
);

    localparam int RW = BASILISK_SQRT_ROOT_WIDTH;
    localparam int MW = BASILISK_SQRT_REM_WIDTH;

    logic [MW-1:0] rem_sh;
    logic [MW:0]   diff;
    // The partial remainder never exceeds 2*Q, so its top two bits are always zero here
    logic          unused_rem_hi;

    assign unused_rem_hi = ^rem_i[MW-1:RW];

    always_comb begin
        rem_sh = {rem_i[RW-1:0], s_i[2*RW-1 -: 2]};
        diff   = {1'b0, rem_sh} - {1'b0, q_i, 2'b01};
        s_o    = {s_i[2*RW-3:0], 2'b00};
        if (!diff[MW]) begin
            rem_o = diff[MW-1:0];
            q_o   = {q_i[RW-2:0], 1'b1};
        end else begin
            rem_o = rem_sh;
            q_o   = {q_i[RW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/basilisk_sqrt_operation.sv
// rtl/basilisk_sqrt_operation.sv - Blocking iterative FSQRT.S mantissa stage (26-bit root + sticky)
// Optional BASILISK_SQRT_BYPASS_EN sends special operands straight to DONE with Q=0, sticky=0.
module basilisk_sqrt_operation
    import basilisk::*;
#(
    parameter int ITERATIONS_PER_CYCLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sqrt_exponent_command_valid,
    output logic                     sqrt_exponent_command_ready,
    input  basilisk_sqrt_operation_t sqrt_exponent_command_payload,
    output logic                     sqrt_result_command_valid,
    input  logic                     sqrt_result_command_ready,
    output basilisk_sqrt_result_t    sqrt_result_command_payload
);

    localparam int         RW       = BASILISK_SQRT_ROOT_WIDTH;
    localparam int         MW       = BASILISK_SQRT_REM_WIDTH;
    localparam logic [4:0] CNT_LOAD = 5'(RW / ITERATIONS_PER_CYCLE - 1);

    generate
        if (ITERATIONS_PER_CYCLE != 1 && ITERATIONS_PER_CYCLE != 2) begin : g_bad_ipc
            $error("ITERATIONS_PER_CYCLE must be 1 or 2");
        end
    endgenerate

    logic [1:0]               state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic                     fin_q, fin_d;
    logic [MW-1:0]            rem_q, rem_d;
    logic [RW-1:0]            root_q, root_d;
    logic [2*RW-1:0]          shift_q, shift_d;
    basilisk_sqrt_operation_t op_q, op_d;
    basilisk_sqrt_result_t    out_q, out_d;
    logic                     in_fire;

    logic [MW-1:0]   rem_c   [ITERATIONS_PER_CYCLE+1];
    logic [RW-1:0]   root_c  [ITERATIONS_PER_CYCLE+1];
    logic [2*RW-1:0] shift_c [ITERATIONS_PER_CYCLE+1];

    assign rem_c[0]   = rem_q;
    assign root_c[0]  = root_q;
    assign shift_c[0] = shift_q;

    for (genvar gi = 0; gi < ITERATIONS_PER_CYCLE; gi++) begin : g_step
        basilisk_sqrt_step u_step (
            .rem_i (rem_c[gi]),
            .q_i   (root_c[gi]),
            .s_i   (shift_c[gi]),
            .rem_o (rem_c[gi+1]),
            .q_o   (root_c[gi+1]),
            .s_o   (shift_c[gi+1])
        );
    end

    assign sqrt_exponent_command_ready = rst & ((state_q == SQRT_IDLE) |
                                                ((state_q == SQRT_DONE) & sqrt_result_command_ready));
    assign sqrt_result_command_valid   = (state_q == SQRT_DONE);
    assign sqrt_result_command_payload = out_q;

    // fin_q adds the cycle that turns the last recurrence state into the output payload
    always_comb begin
        in_fire = sqrt_exponent_command_valid & sqrt_exponent_command_ready;
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        rem_d   = rem_q;
        root_d  = root_q;
        shift_d = shift_q;
        op_d    = op_q;
        out_d   = out_q;
        case (state_q)
            SQRT_IDLE: ;
            SQRT_ITERATE: begin
                if (fin_q) begin
                    state_d              = SQRT_DONE;
                    out_d.result         = op_q.result;
                    out_d.result.mant    = root_q;
                    out_d.sticky         = |rem_q;
                    out_d.mode           = op_q.mode;
                    out_d.dest_reg_addr  = op_q.dest_reg_addr;
                end else begin
                    rem_d   = rem_c[ITERATIONS_PER_CYCLE];
                    root_d  = root_c[ITERATIONS_PER_CYCLE];
                    shift_d = shift_c[ITERATIONS_PER_CYCLE];
                    if (cnt_q == 5'd0) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end
            SQRT_DONE: begin
                if (sqrt_result_command_ready) begin
                    state_d = SQRT_IDLE;
                end
            end
            default: state_d = SQRT_IDLE;
        endcase
        if (in_fire) begin
            state_d = SQRT_ITERATE;
            cnt_d   = CNT_LOAD;
            fin_d   = 1'b0;
            rem_d   = '0;
            root_d  = '0;
            shift_d = {sqrt_exponent_command_payload.result.mant, {RW{1'b0}}};
            op_d    = sqrt_exponent_command_payload;
`ifdef BASILISK_SQRT_BYPASS_EN
            if (basilisk_sqrt_is_special(sqrt_exponent_command_payload.result)) begin
                fin_d = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SQRT_IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            rem_q   <= '0;
            root_q  <= '0;
            shift_q <= '0;
            op_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            shift_q <= shift_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_basilisk_sqrt_operation.sv
// tb/tb_basilisk_sqrt_operation.sv - Self-checking bench: directed cases at 1 step/cycle, random at 2
module tb_basilisk_sqrt_operation;
    import basilisk::*;

`ifdef BASILISK_SQRT_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        basilisk_sqrt_result_t pl;
        int                    due;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid  [2];
    logic                     in_ready  [2];
    basilisk_sqrt_operation_t in_pl     [2];
    logic                     out_valid [2];
    logic                     out_ready [2];
    basilisk_sqrt_result_t    out_pl    [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_acc [2];
    int   last_hs  [2];
    exp_t sb [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    basilisk_sqrt_operation #(.ITERATIONS_PER_CYCLE(1)) u_dut1 (
        .clk                           (clk),
        .rst                           (rst),
        .sqrt_exponent_command_valid   (in_valid[0]),
        .sqrt_exponent_command_ready   (in_ready[0]),
        .sqrt_exponent_command_payload (in_pl[0]),
        .sqrt_result_command_valid     (out_valid[0]),
        .sqrt_result_command_ready     (out_ready[0]),
        .sqrt_result_command_payload   (out_pl[0])
    );

    basilisk_sqrt_operation #(.ITERATIONS_PER_CYCLE(2)) u_dut2 (
        .clk                           (clk),
        .rst                           (rst),
        .sqrt_exponent_command_valid   (in_valid[1]),
        .sqrt_exponent_command_ready   (in_ready[1]),
        .sqrt_exponent_command_payload (in_pl[1]),
        .sqrt_result_command_valid     (out_valid[1]),
        .sqrt_result_command_ready     (out_ready[1]),
        .sqrt_result_command_payload   (out_pl[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Largest q with q*q <= R*2^26, found by binary search
    function automatic void model_sqrt(input logic [25:0] r, output logic [25:0] q, output logic st);
        longint unsigned n, lo, hi, mid;
        n  = longint'(r) << 26;
        lo = 0;
        hi = (64'd1 << 26) - 1;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid - 1;
        end
        q  = 26'(lo);
        st = (lo * lo != n);
    endfunction

    function automatic logic is_special(input basilisk_sqrt_operation_t op);
        return op.result.nan | op.result.inf | op.result.zero | op.result.invalid;
    endfunction

    function automatic basilisk_sqrt_result_t model_result(input basilisk_sqrt_operation_t op);
        basilisk_sqrt_result_t res;
        logic [25:0] q;
        logic        st;
        model_sqrt(op.result.mant, q, st);
        if (BYPASS && is_special(op)) begin
            q  = '0;
            st = 1'b0;
        end
        res.result        = op.result;
        res.result.mant   = q;
        res.sticky        = st;
        res.mode          = op.mode;
        res.dest_reg_addr = op.dest_reg_addr;
        return res;
    endfunction

    function automatic int model_lat(input basilisk_sqrt_operation_t op, input int ipc);
        if (BYPASS && is_special(op)) return 1;
        return 26 / ipc + 1;
    endfunction

    function automatic basilisk_sqrt_operation_t mk_op(input logic [25:0] r, input logic [4:0] dest,
                                                       input logic [3:0] flags);
        basilisk_sqrt_operation_t op;
        op.result.sign     = 1'($urandom);
        op.result.exponent = 10'($urandom);
        {op.result.nan, op.result.inf, op.result.zero, op.result.invalid} = flags;
        op.result.mant     = r;
        op.mode            = 3'($urandom);
        op.dest_reg_addr   = dest;
        return op;
    endfunction

    // Scoreboard compare: valid, ready and payload are checked on every cycle out of reset
    always @(negedge clk) begin
        bit   exp_v, exp_r;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                sb[i].delete();
                chk($sformatf("rst_ready%0d", i), 64'(in_ready[i]), 64'd0);
                chk($sformatf("rst_valid%0d", i), 64'(out_valid[i]), 64'd0);
            end else begin
                exp_v = (sb[i].size() > 0) && (cyc >= sb[i][0].due);
                exp_r = (sb[i].size() == 0) || (exp_v && out_ready[i]);
                chk($sformatf("valid%0d", i), 64'(out_valid[i]), 64'(exp_v));
                chk($sformatf("ready%0d", i), 64'(in_ready[i]), 64'(exp_r));
                if (exp_v && out_valid[i])
                    chk($sformatf("payload%0d", i), 64'(out_pl[i]), 64'(sb[i][0].pl));
                if (out_valid[i] && out_ready[i]) last_hs[i] = cyc + 1;
                if (in_valid[i] && in_ready[i]) last_acc[i] = cyc + 1;
                if (exp_v && out_ready[i]) void'(sb[i].pop_front());
                if (in_valid[i] && exp_r) begin
                    e.pl  = model_result(in_pl[i]);
                    e.due = cyc + 1 + model_lat(in_pl[i], (i == 0) ? 1 : 2);
                    sb[i].push_back(e);
                end
            end
        end
    end

    task automatic send(input int i, input basilisk_sqrt_operation_t op, input bit bp);
        in_pl[i]    = op;
        in_valid[i] = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready[i]) begin
                @(posedge clk);
                #1;
                in_valid[i] = 1'b0;
                if (bp) out_ready[i] = ($urandom_range(0, 3) != 0);
                return;
            end
            @(posedge clk);
            #1;
            if (bp) out_ready[i] = ($urandom_range(0, 3) != 0);
        end
        chk("send_timeout", 64'(in_ready[i]), 64'd1);
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_out(input int i, output basilisk_sqrt_result_t pl);
        pl = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid[i]) begin
                pl = out_pl[i];
                return;
            end
        end
        chk("wait_out_timeout", 64'(out_valid[i]), 64'd1);
    endtask

    task automatic directed(input string tag, input int i, input basilisk_sqrt_operation_t op,
                            input logic [25:0] eq, input logic es, input int elat);
        basilisk_sqrt_result_t got;
        int acc;
        send(i, op, 1'b0);
        acc = cyc;
        wait_out(i, got);
        chk({tag, "_latency"}, 64'(cyc - acc), 64'(elat));
        chk({tag, "_root"}, 64'(got.result.mant), 64'(eq));
        chk({tag, "_sticky"}, 64'(got.sticky), 64'(es));
        chk({tag, "_flags"}, 64'({got.result.nan, got.result.inf, got.result.zero, got.result.invalid}),
            64'({op.result.nan, op.result.inf, op.result.zero, op.result.invalid}));
        chk({tag, "_exponent"}, 64'(got.result.exponent), 64'(op.result.exponent));
        chk({tag, "_dest"}, 64'(got.dest_reg_addr), 64'(op.dest_reg_addr));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        basilisk_sqrt_operation_t opa, opb, opr;
        basilisk_sqrt_result_t    got, held;
        logic [25:0] mq;
        logic        ms;
        logic [25:0] r;
        logic [3:0]  fl;
        int          bad;

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_pl[i]     = '0;
            out_ready[i] = 1'b1;
            last_acc[i]  = -1;
            last_hs[i]   = -1;
        end

        model_sqrt(26'h1000000, mq, ms);
        chk("model_1p0", 64'({mq, ms}), 64'({26'h2000000, 1'b0}));
        model_sqrt(26'h2000000, mq, ms);
        chk("model_2p0", 64'({mq, ms}), 64'({26'h2D413CC, 1'b1}));
        model_sqrt(26'h2400000, mq, ms);
        chk("model_2p25", 64'({mq, ms}), 64'({26'h3000000, 1'b0}));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_payload", 64'(out_pl[0]), 64'd0);
        chk("reset_valid", 64'(out_valid[0]), 64'd0);
        chk("reset_ready", 64'(in_ready[0]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;

        directed("r1p0", 0, mk_op(26'h1000000, 5'd1, 4'b0000), 26'h2000000, 1'b0, 27);
        directed("r2p0", 0, mk_op(26'h2000000, 5'd2, 4'b0000), 26'h2D413CC, 1'b1, 27);
        directed("r2p25", 0, mk_op(26'h2400000, 5'd3, 4'b0000), 26'h3000000, 1'b0, 27);
        directed("zero_flag", 0, mk_op(26'h2000000, 5'd4, 4'b0010),
                 BYPASS ? 26'h0 : 26'h2D413CC, BYPASS ? 1'b0 : 1'b1, BYPASS ? 1 : 27);

        // Back-to-back with a stalled first result
        opa = mk_op(26'h3000000, 5'd5, 4'b0000);
        opb = mk_op(26'h1000000, 5'd6, 4'b0000);
        out_ready[0] = 1'b0;
        send(0, opa, 1'b0);
        wait_out(0, held);
        chk("b2b_first_dest", 64'(held.dest_reg_addr), 64'd5);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            in_pl[0]    = opb;
            in_valid[0] = 1'b1;
            @(negedge clk);
            chk("stall_payload", 64'(out_pl[0]), 64'(held));
            chk("stall_valid", 64'(out_valid[0]), 64'd1);
            chk("stall_ready", 64'(in_ready[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        last_acc[0]  = -1;
        last_hs[0]   = -1;
        @(negedge clk);
        chk("b2b_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        chk("b2b_accept_edge", 64'(last_acc[0]), 64'(cyc));
        chk("b2b_handshake_edge", 64'(last_hs[0]), 64'(cyc));
        wait_out(0, got);
        chk("b2b_second_dest", 64'(got.dest_reg_addr), 64'd6);
        chk("b2b_second_root", 64'(got.result.mant), 64'h2000000);
        @(posedge clk);
        #1;

        // Reset in the middle of an iteration
        send(0, mk_op(26'h2000000, 5'd7, 4'b0000), 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", 64'(in_ready[0]), 64'd1);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid[0]) bad++;
        end
        chk("abort_no_output", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        directed("after_abort", 0, mk_op(26'h1000000, 5'd8, 4'b0000), 26'h2000000, 1'b0, 27);

        // Two steps per cycle: one pinned case, then random operands with random backpressure
        directed("ipc2_2p25", 1, mk_op(26'h2400000, 5'd9, 4'b0000), 26'h3000000, 1'b0, 14);
        for (int n = 0; n < 1000; n++) begin
            if (n == 0) r = 26'h1000000;
            else if (n == 1) r = 26'h3FFFFFF;
            else r = 26'($urandom_range(32'h1000000, 32'h3FFFFFF));
            fl  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            opr = mk_op(r, 5'(n), fl);
            send(1, opr, 1'b1);
        end
        out_ready[1] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sb[1].size() == 0) break;
        end
        chk("drain", 64'(sb[1].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
